acc_mem_arb: RTL and testbench

ACC_MEM_ARB -- requirements
Module: acc_mem_arb

---
 rtl/acc_pkg.sv | 31 +++
 rtl/acc_arb_perf.sv | 45 ++++
 rtl/acc_mem_arb.sv | 157 +++++++++++++++
 tb/tb_acc_mem_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
//   Shared types and constants for the accelerator memory subsystem.
//
//   halfword_t  - 16-bit word address into the shared frame memory
//   word_t      - 32-bit memory data word
//   arb_state_t - ownership state of the memory-port arbiter
//   IMG_W / IMG_H / WORDS_PER_ROW - frame geometry (CIF, 4 pixels per word)
//   STALL_MAX   - saturation value of the optional stall counter
//
//   The optional stall counter is built only when the macro
//   ACC_ARB_PERF_EN is defined.
// ---------------------------------------------------------------------------
package acc_pkg;

   localparam int IMG_W         = 352;
   localparam int IMG_H         = 288;
   localparam int WORDS_PER_ROW = 88;

   typedef logic [15:0] halfword_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_RD = 2'd1,
      OWN_WR = 2'd2
   } arb_state_t;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage : acc_pkg

// File: rtl/acc_arb_perf.sv
// ---------------------------------------------------------------------------
// acc_arb_perf
//   Stall counter for the memory-port arbiter. Counts every cycle in which
//   at least one requester is asking for the port but is not granted.
//   Saturates at 16'hFFFF and clears on reset. Instantiated by acc_mem_arb
//   only when ACC_ARB_PERF_EN is defined.
//
//   Ports
//     clk       in   clock, rising edge
//     reset     in   synchronous active-high reset
//     rd_req    in   read requester is asking
//     rd_gnt    in   read requester granted this cycle
//     wr_req    in   write requester is asking
//     wr_gnt    in   write requester granted this cycle
//     stall_cnt out  stall cycle count (16 bits, saturating)
// ---------------------------------------------------------------------------
module acc_arb_perf
   import acc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic        rd_gnt,
   input  logic        wr_req,
   input  logic        wr_gnt,
   output logic [15:0] stall_cnt
);

   logic [15:0] stall_reg;
   logic        stalled;

   // A cycle counts once even if both sides happen to be waiting.
   assign stalled = (rd_req & ~rd_gnt) | (wr_req & ~wr_gnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_reg <= '0;
      end else if (stalled && (stall_reg != STALL_MAX)) begin
         stall_reg <= stall_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_reg;

endmodule : acc_arb_perf

// File: rtl/acc_mem_arb.sv
// ---------------------------------------------------------------------------
// acc_mem_arb
//   Two-requester arbiter (one reader, one writer) in front of a single
//   synchronous memory port. The current owner keeps the port while it
//   requests, for at most MAX_BURST consecutive grants while the other side
//   waits; after that the waiting side takes over. From IDLE, read wins a
//   simultaneous request. Grants and the memory port signals are
//   combinational (zero added latency); read data comes back one cycle
//   after the read grant on rd_data/rd_valid.
//
//   Parameters
//     MAX_BURST  max consecutive grants to one side while the other waits
//
//   Ports
//     clk, reset         clock and synchronous active-high reset
//     rd_req/rd_addr     read request and word address
//     rd_gnt             read accepted this cycle
//     rd_valid/rd_data   read data for the previous cycle's read grant
//     wr_req/wr_addr/wr_data  write request, word address and data
//     wr_gnt             write accepted this cycle
//     addr/dataW/en/we   memory port outputs (all zero when idle)
//     dataR              memory read data (valid one cycle after en & ~we)
//     stall_cnt          only with ACC_ARB_PERF_EN: stall cycle counter
// ---------------------------------------------------------------------------
module acc_mem_arb
   import acc_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   // read requester
   input  logic        rd_req,
   input  halfword_t   rd_addr,
   output logic        rd_gnt,
   output logic        rd_valid,
   output word_t       rd_data,
   // write requester
   input  logic        wr_req,
   input  halfword_t   wr_addr,
   input  word_t       wr_data,
   output logic        wr_gnt,
   // shared memory port
   output halfword_t   addr,
   input  word_t       dataR,
   output word_t       dataW,
   output logic        en,
   output logic        we
`ifdef ACC_ARB_PERF_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   localparam int               CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

   arb_state_t       state_reg;
   arb_state_t       state_next;
   logic [CNT_W-1:0] burst_reg;
   logic [CNT_W-1:0] burst_next;
   logic [CNT_W-1:0] burst_inc;
   logic             burst_full;
   logic             rd_valid_reg;
   logic             pick_rd;
   logic             pick_wr;

   assign burst_full = (burst_reg == BURST_MAX);
   // Saturating increment: an unopposed owner may run past MAX_BURST.
   assign burst_inc  = burst_full ? burst_reg : burst_reg + BURST_ONE;

   // Grant decision. The owner yields only when it stops requesting, or when
   // it has used up its burst and the other side is waiting; in both cases
   // the other side is granted in the same cycle, so no idle cycle appears.
   always_comb begin
      pick_rd = 1'b0;
      pick_wr = 1'b0;
      case (state_reg)
         OWN_RD: begin
            if (rd_req && !(wr_req && burst_full)) begin
               pick_rd = 1'b1;
            end else if (wr_req) begin
               pick_wr = 1'b1;
            end
         end
         OWN_WR: begin
            if (wr_req && !(rd_req && burst_full)) begin
               pick_wr = 1'b1;
            end else if (rd_req) begin
               pick_rd = 1'b1;
            end
         end
         default: begin
            // IDLE (and any unreachable encoding): read has priority.
            if (rd_req) begin
               pick_rd = 1'b1;
            end else if (wr_req) begin
               pick_wr = 1'b1;
            end
         end
      endcase
   end

   // Next ownership and burst length follow directly from who was granted.
   always_comb begin
      state_next = IDLE;
      burst_next = '0;
      if (pick_rd) begin
         state_next = OWN_RD;
         burst_next = (state_reg == OWN_RD) ? burst_inc : BURST_ONE;
      end else if (pick_wr) begin
         state_next = OWN_WR;
         burst_next = (state_reg == OWN_WR) ? burst_inc : BURST_ONE;
      end
   end

   // State register. A read picked in a reset cycle never produces rd_valid
   // because the reset branch overrides the capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         burst_reg    <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         burst_reg    <= burst_next;
         rd_valid_reg <= pick_rd;
      end
   end

   // Grants are masked by reset so the port stays quiet for the whole
   // reset cycle, not just after the clock edge.
   assign rd_gnt   = pick_rd & ~reset;
   assign wr_gnt   = pick_wr & ~reset;

   assign en       = rd_gnt | wr_gnt;
   assign we       = wr_gnt;
   assign addr     = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
   assign dataW    = wr_gnt ? wr_data : '0;

   assign rd_valid = rd_valid_reg & ~reset;
   assign rd_data  = rd_valid ? dataR : '0;

`ifdef ACC_ARB_PERF_EN
   acc_arb_perf u_perf (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req),
      .rd_gnt    (rd_gnt),
      .wr_req    (wr_req),
      .wr_gnt    (wr_gnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule : acc_mem_arb

// File: tb/tb_acc_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_acc_mem_arb
//   Self-checking bench for acc_mem_arb: a table of directed cycles, a
//   randomized run against a grant/streak reference model with a shadow
//   memory, and (with ACC_ARB_PERF_EN) a stall counter sequence.
// ---------------------------------------------------------------------------
module tb_acc_mem_arb;
   import acc_pkg::*;

   localparam int MAX_BURST = 4;
   localparam int N_RAND    = 800;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   halfword_t   rd_addr;
   logic        rd_gnt;
   logic        rd_valid;
   word_t       rd_data;
   logic        wr_req;
   halfword_t   wr_addr;
   word_t       wr_data;
   logic        wr_gnt;
   halfword_t   addr;
   word_t       dataR;
   word_t       dataW;
   logic        en;
   logic        we;
`ifdef ACC_ARB_PERF_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   acc_mem_arb #(.MAX_BURST(MAX_BURST)) dut (
      .clk      (clk),
      .reset    (reset),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_gnt   (rd_gnt),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_gnt   (wr_gnt),
      .addr     (addr),
      .dataR    (dataR),
      .dataW    (dataW),
      .en       (en),
      .we       (we)
`ifdef ACC_ARB_PERF_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   // Synchronous memory behind the port; contents start as A500_00xx.
   logic  mem_init;
   word_t mem [0:255];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (en) begin
         if (we) mem[addr[7:0]] <= dataW;
         else    dataR <= mem[addr[7:0]];
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   // Compares every port output against the grant expected this cycle.
   task automatic check_cycle(input string tag, input logic g_rd, input logic g_wr,
                              input halfword_t ra, input halfword_t wa, input word_t wd,
                              input logic rv, input word_t rdata);
      logic      e_en;
      halfword_t e_addr;
      word_t     e_dw;
      e_en   = g_rd | g_wr;
      e_addr = g_wr ? wa : (g_rd ? ra : 16'h0000);
      e_dw   = g_wr ? wd : 32'h0;
      check({tag, ".rd_gnt"},   32'(rd_gnt),   32'(g_rd));
      check({tag, ".wr_gnt"},   32'(wr_gnt),   32'(g_wr));
      check({tag, ".en"},       32'(en),       32'(e_en));
      check({tag, ".we"},       32'(we),       32'(g_wr));
      check({tag, ".addr"},     32'(addr),     32'(e_addr));
      check({tag, ".dataW"},    dataW,         e_dw);
      check({tag, ".rd_valid"}, 32'(rd_valid), 32'(rv));
      check({tag, ".rd_data"},  rd_data,       rv ? rdata : 32'h0);
   endtask

   typedef struct {
      logic      rst;
      logic      rr;
      halfword_t ra;
      logic      wr;
      halfword_t wa;
      word_t     wd;
      logic      g_rd;
      logic      g_wr;
      logic      rv;
      word_t     rdata;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic rr, input halfword_t ra,
                               input logic wr, input halfword_t wa, input word_t wd,
                               input logic g_rd, input logic g_wr,
                               input logic rv, input word_t rdata);
      vec_t v;
      v.rst = rst; v.rr = rr; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd;
      v.g_rd = g_rd; v.g_wr = g_wr; v.rv = rv; v.rdata = rdata;
      tbl.push_back(v);
   endfunction

   // Random-phase model state.
   word_t     shadow [0:255];
   int        last_g;
   int        streak;
   int        exp_g;
   logic      exp_rv;
   word_t     exp_rdata;
   logic      rd_pend, wr_pend;
   halfword_t ra_r, wa_r;
   word_t     wd_r;
   int        rd_wait, wr_wait;

   initial begin
      reset    = 1'b1;
      mem_init = 1'b1;
      rd_req   = 1'b0; rd_addr = '0;
      wr_req   = 1'b0; wr_addr = '0; wr_data = '0;
      @(posedge clk); #1;
      mem_init = 1'b0;

      // ---------------- directed table ----------------
      // reset holds everything quiet even with both requesting
      add(1, 1, 16'h0058, 1, 16'h0020, 32'h0000_0001, 0, 0, 0, 0);
      add(1, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      // lone read of 0x0058, data next cycle
      add(0, 1, 16'h0058, 0, 16'h0000, 32'h0,         1, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 1, 32'hA500_0058);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      // simultaneous from IDLE: read first, write when read drops
      add(0, 1, 16'h0010, 1, 16'h0020, 32'h1111_2222, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 16'h0020, 32'h1111_2222, 0, 1, 1, 32'hA500_0010);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      // both held 12 cycles: 4 reads, 4 writes, 4 reads
      for (int k = 0; k < 12; k++) begin
         add(0, 1, 16'h0030, 1, 16'h0040, 32'h3333_4444,
             (k < 4 || k >= 8), (k >= 4 && k < 8),
             ((k >= 1 && k <= 4) || k >= 9), 32'hA500_0030);
      end
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 1, 32'hA500_0030);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      // lone write for 10 cycles
      for (int k = 0; k < 10; k++) begin
         add(0, 0, 16'h0000, 1, 16'h0050, 32'hD000_0000 + 32'(k), 0, 1, 0, 0);
      end
      // burst count is saturated, so a new read takes over at once
      add(0, 1, 16'h0060, 1, 16'h0050, 32'hD000_00FF, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 16'h0050, 32'hD000_00FF, 0, 1, 1, 32'hA500_0060);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      add(0, 1, 16'h0050, 0, 16'h0000, 32'h0,         1, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 1, 32'hD000_00FF);
      // reset during a read: quiet in that cycle and no rd_valid afterwards
      add(0, 1, 16'h0058, 0, 16'h0000, 32'h0,         1, 0, 0, 0);
      add(1, 1, 16'h0058, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      // back in IDLE after reset: read wins again; write data lands in memory
      add(0, 1, 16'h0030, 1, 16'h0040, 32'h5555_6666, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 16'h0040, 32'h5555_6666, 0, 1, 1, 32'hA500_0030);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 0, 0);
      add(0, 1, 16'h0040, 0, 16'h0000, 32'h0,         1, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 16'h0000, 32'h0,         0, 0, 1, 32'h5555_6666);

      foreach (tbl[i]) begin
         reset   = tbl[i].rst;
         rd_req  = tbl[i].rr;
         rd_addr = tbl[i].ra;
         wr_req  = tbl[i].wr;
         wr_addr = tbl[i].wa;
         wr_data = tbl[i].wd;
         @(negedge clk);
         $display("vec %0d rst=%0b rd_req=%0b wr_req=%0b -> rd_gnt=%0b wr_gnt=%0b addr=%04h rd_valid=%0b rd_data=%08h",
                  i, tbl[i].rst, tbl[i].rr, tbl[i].wr, rd_gnt, wr_gnt, addr, rd_valid, rd_data);
         check_cycle($sformatf("v%0d", i), tbl[i].g_rd, tbl[i].g_wr, tbl[i].ra,
                     tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].rdata);
         @(posedge clk); #1;
      end

      // ---------------- randomized run ----------------
      // Model: who was granted last and how many times in a row. The
      // holder keeps a contested port until it has had MAX_BURST grants.
      for (int i = 0; i < 256; i++) shadow[i] = 32'hA500_0000 | 32'(i);
      last_g  = 0; streak = 0;
      exp_rv  = 1'b0; exp_rdata = '0;
      rd_pend = 1'b0; wr_pend = 1'b0;
      rd_wait = 0; wr_wait = 0;
      ra_r = '0; wa_r = '0; wd_r = '0;
      reset = 1'b0;

      for (int n = 0; n < N_RAND; n++) begin
         logic      g_rd, g_wr, nxt_rv;
         word_t     nxt_rdata;
         if (!rd_pend && $urandom_range(0, 3) != 0) begin
            rd_pend = 1'b1;
            ra_r    = 16'h0080 + 16'($urandom_range(0, 31));
            rd_wait = 0;
         end
         if (!wr_pend && $urandom_range(0, 3) != 0) begin
            wr_pend = 1'b1;
            wa_r    = 16'h0080 + 16'($urandom_range(0, 31));
            wd_r    = $urandom;
            wr_wait = 0;
         end
         rd_req  = rd_pend;
         rd_addr = rd_pend ? ra_r : 16'($urandom);
         wr_req  = wr_pend;
         wr_addr = wr_pend ? wa_r : 16'($urandom);
         wr_data = wr_pend ? wd_r : $urandom;

         if (rd_pend && wr_pend) begin
            if (last_g == 2)      exp_g = (streak >= MAX_BURST) ? 1 : 2;
            else if (last_g == 1) exp_g = (streak >= MAX_BURST) ? 2 : 1;
            else                  exp_g = 1;
         end else if (rd_pend) begin
            exp_g = 1;
         end else if (wr_pend) begin
            exp_g = 2;
         end else begin
            exp_g = 0;
         end
         g_rd = (exp_g == 1);
         g_wr = (exp_g == 2);

         @(negedge clk);
         $display("rand %0d rd_req=%0b wr_req=%0b -> rd_gnt=%0b wr_gnt=%0b addr=%04h rd_valid=%0b rd_data=%08h",
                  n, rd_req, wr_req, rd_gnt, wr_gnt, addr, rd_valid, rd_data);
         check_cycle($sformatf("r%0d", n), g_rd, g_wr, ra_r, wa_r, wd_r, exp_rv, exp_rdata);

         nxt_rv    = 1'b0;
         nxt_rdata = '0;
         if (g_rd) begin
            check($sformatf("r%0d.rd_wait_le_max", n), 32'(rd_wait <= MAX_BURST), 32'd1);
            nxt_rv    = 1'b1;
            nxt_rdata = shadow[ra_r[7:0]];
            rd_pend   = 1'b0;
         end else if (rd_pend) begin
            rd_wait++;
         end
         if (g_wr) begin
            check($sformatf("r%0d.wr_wait_le_max", n), 32'(wr_wait <= MAX_BURST), 32'd1);
            shadow[wa_r[7:0]] = wd_r;
            wr_pend = 1'b0;
         end else if (wr_pend) begin
            wr_wait++;
         end
         if (exp_g == 0) begin
            last_g = 0; streak = 0;
         end else if (exp_g == last_g) begin
            streak = (streak + 1 > MAX_BURST) ? MAX_BURST : streak + 1;
         end else begin
            last_g = exp_g; streak = 1;
         end
         exp_rv    = nxt_rv;
         exp_rdata = nxt_rdata;
         @(posedge clk); #1;
      end

`ifdef ACC_ARB_PERF_EN
      // ---------------- stall counter ----------------
      rd_req = 1'b0; wr_req = 1'b0;
      reset  = 1'b1;
      @(posedge clk); #1;
      reset  = 1'b0;
      @(negedge clk);
      check("perf.after_reset", 32'(stall_cnt), 32'd0);
      @(posedge clk); #1;
      // both rise from IDLE: the write waits through 4 read grants
      rd_req = 1'b1; rd_addr = 16'h0090;
      wr_req = 1'b1; wr_addr = 16'h0091; wr_data = 32'hCAFE_0001;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         $display("perf %0d rd_gnt=%0b wr_gnt=%0b stall_cnt=%0d", k, rd_gnt, wr_gnt, stall_cnt);
         if (k == 4) begin
            check("perf.wr_gnt", 32'(wr_gnt), 32'd1);
            check("perf.stall_cnt", 32'(stall_cnt), 32'd4);
         end
         @(posedge clk); #1;
         if (k == 3) rd_req = 1'b0;
      end
      wr_req = 1'b0;
      @(posedge clk); #1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_acc_mem_arb
